// File: rtl/ext_slow_mem_responder_if.sv
// OBI request/response bundle between a master and the slow-memory responder.
// Latency: none (wires only).
// Backpressure: request side is valid/grant; the response side has none, so the master must always accept rvalid.
//
// Signals (direction as seen by the responder):
//   req_i    in   request valid
//   gnt_o    out  grant
//   addr_i   in   32-bit byte address
//   we_i     in   1 = write, 0 = read
//   be_i     in   byte enables (writes only)
//   wdata_i  in   write data
//   rvalid_o out  response valid, one cycle per accepted request
//   rdata_o  out  read data, 0 for write responses and idle cycles
interface ext_slow_mem_responder_if;
    logic        req_i;
    logic        gnt_o;
    logic [31:0] addr_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] wdata_i;
    logic        rvalid_o;
    logic [31:0] rdata_o;

    modport master (
        output req_i, addr_i, we_i, be_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o
    );

    modport slave (
        input  req_i, addr_i, we_i, be_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o
    );
endinterface

// File: rtl/ext_slow_mem_responder.sv
// OBI slave for the external slow-memory window: a word-addressed RAM that answers each request in order after a delay.
// Latency: a grant in cycle t into an empty queue gives rvalid_o in cycle t+LATENCY (plus 0..7 random cycles with EXT_SLOW_MEM_RAND_LAT_EN).
// Backpressure: gnt_o drops while MAX_OUTSTANDING responses are pending; responses cannot be stalled.
//
// Ports:
//   clk_i  in   clock
//   rst_i  in   asynchronous active-high reset (clears the response queue, not the memory)
//   bus    slave modport of ext_slow_mem_responder_if (req/gnt/addr/we/be/wdata, rvalid/rdata)
//
// Optional feature: define EXT_SLOW_MEM_RAND_LAT_EN to add a pseudo-random 0..7 cycles to every
// response delay (16-bit Fibonacci LFSR, taps 16,14,13,11, stepped on granted cycles).
module ext_slow_mem_responder #(
    parameter logic [31:0] BASE_ADDR       = 32'hF000_0000, // EXT_SLAVE_START_ADDRESS
    parameter logic [31:0] SIZE_BYTES      = 32'h0000_0400,
    parameter int unsigned LATENCY         = 3,             // 1..15
    parameter int unsigned MAX_OUTSTANDING = 2              // 1..8
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    ext_slow_mem_responder_if.slave        bus
);

    localparam int unsigned NUM_WORDS = SIZE_BYTES / 4;
    localparam int unsigned IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int unsigned CNT_W     = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [31:0] OOR_RDATA = 32'hBADC_AB1E;

    // One pending response. dly counts the cycles left before the edge that
    // pops the entry and raises rvalid_o.
    typedef struct packed {
        logic [31:0] rdata;
        logic [4:0]  dly;
    } q_entry_t;

    // ------------------------------------------------------------------
    // Storage (deliberately not reset)
    // ------------------------------------------------------------------
    logic [31:0] mem_q [NUM_WORDS];

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [31:0]      offset;
    logic             in_range;
    logic [IDX_W-1:0] word_idx;

    // Comparing the offset rather than BASE_ADDR+SIZE_BYTES keeps the upper
    // bound correct even if the window ends at the top of the address space.
    assign offset   = bus.addr_i - BASE_ADDR;
    assign in_range = (bus.addr_i >= BASE_ADDR) && (offset < SIZE_BYTES);
    assign word_idx = offset[IDX_W+1:2];

    // ------------------------------------------------------------------
    // Grant
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             grant;

    // Uses the registered count only: a pop in the same cycle does not free a
    // slot for this cycle's request.
    assign grant     = bus.req_i && (count_q < CNT_W'(MAX_OUTSTANDING));
    assign bus.gnt_o = grant;

    // ------------------------------------------------------------------
    // Response delay for the request granted this cycle
    // ------------------------------------------------------------------
    logic [4:0] new_dly;

`ifdef EXT_SLOW_MEM_RAND_LAT_EN
    logic [15:0] lfsr_q;

    assign new_dly = 5'(LATENCY) + {2'b00, lfsr_q[2:0]};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_q <= 16'hACE1;
        end else if (grant) begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end
`else
    assign new_dly = 5'(LATENCY);
`endif

    // ------------------------------------------------------------------
    // Access on the grant edge
    // ------------------------------------------------------------------
    logic [31:0] new_rdata;

    // Read data is captured when the request is granted, so a later write
    // cannot change a response that is already queued.
    always_comb begin
        new_rdata = '0;
        if (!bus.we_i) begin
            new_rdata = in_range ? mem_q[word_idx] : OOR_RDATA;
        end
    end

    always_ff @(posedge clk_i) begin
        if (grant && bus.we_i && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.be_i[b]) begin
                    mem_q[word_idx][8*b +: 8] <= bus.wdata_i[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Response queue (index 0 is the head)
    // ------------------------------------------------------------------
    q_entry_t         q_q   [MAX_OUTSTANDING];
    q_entry_t         q_d   [MAX_OUTSTANDING];
    q_entry_t         q_ext [MAX_OUTSTANDING+1];
    logic             pop;
    logic             bypass;
    logic             push;
    logic [CNT_W-1:0] wr_pos;
    logic             rvalid_q;
    logic             rvalid_d;
    logic [31:0]      rdata_q;
    logic [31:0]      rdata_d;

    // An entry is visible in the queue from the cycle after its grant and the
    // registered rvalid adds one more cycle, so an entry is stored with
    // delay-2. A one-cycle delay cannot be met through the queue, so such a
    // request into an empty queue answers straight from the grant cycle.
    assign pop    = (count_q != '0) && (q_q[0].dly == 5'd0);
    assign bypass = grant && (count_q == '0) && (new_dly <= 5'd1);
    assign push   = grant && !bypass;
    assign wr_pos = count_q - CNT_W'(pop);

    always_comb begin
        // Extra zero slot so the shift-down of the last entry stays in range.
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            q_ext[i] = q_q[i];
        end
        q_ext[MAX_OUTSTANDING] = '0;

        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            q_d[i] = pop ? q_ext[i+1] : q_ext[i];
            // Entries count down regardless of position; one that reaches 0
            // behind the head simply waits there.
            if (q_d[i].dly != 5'd0) begin
                q_d[i].dly = q_d[i].dly - 5'd1;
            end
            if (push && (CNT_W'(i) == wr_pos)) begin
                q_d[i].rdata = new_rdata;
                q_d[i].dly   = (new_dly >= 5'd2) ? (new_dly - 5'd2) : 5'd0;
            end
        end
    end

    assign count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    assign rvalid_d = pop || bypass;

    always_comb begin
        rdata_d = '0;
        if (pop) begin
            rdata_d = q_q[0].rdata;
        end else if (bypass) begin
            rdata_d = new_rdata;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q  <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                q_q[i] <= '0;
            end
        end else begin
            count_q  <= count_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                q_q[i] <= q_d[i];
            end
        end
    end

    assign bus.rvalid_o = rvalid_q;
    assign bus.rdata_o  = rdata_q;

endmodule

// File: tb/tb_ext_slow_mem_responder.sv
// Directed bench for ext_slow_mem_responder: latency, byte enables, grant throttling, decode, reset.
// Latency: n/a.
// Backpressure: the bench always accepts responses.
module tb_ext_slow_mem_responder;

    localparam logic [31:0] BASE = 32'hF000_0000;
    localparam int          LAT  = 3;
    localparam int          MAXO = 2;
    localparam int EXP_G [4] = '{0, 1, 3, 4};
    localparam int EXP_R [4] = '{3, 4, 6, 7};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ext_slow_mem_responder_if bus ();

    ext_slow_mem_responder #(
        .BASE_ADDR       (BASE),
        .SIZE_BYTES      (32'h400),
        .LATENCY         (LAT),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Cycle counter and bus monitor (sampled on the falling edge)
    int          cyc = 0;
    int          g_cyc [$];
    int          r_cyc [$];
    logic [31:0] r_dat [$];
    int          mcnt     = 0;
    int          full_gnt = 0;
    int          idle_dat = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            mcnt = 0;
        end else begin
            if (bus.rvalid_o) begin
                r_cyc.push_back(cyc);
                r_dat.push_back(bus.rdata_o);
                mcnt--;
            end else if (bus.rdata_o !== 32'h0) begin
                idle_dat++;
            end
            if (bus.req_i && bus.gnt_o) begin
                if (mcnt >= MAXO) full_gnt++;
                g_cyc.push_back(cyc);
                mcnt++;
            end
        end
    end

    // Request list consumed by run_reqs
    logic        q_we   [$];
    logic [31:0] q_addr [$];
    logic [3:0]  q_be   [$];
    logic [31:0] q_wd   [$];

    task automatic add_req(input logic we, input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd);
        q_we.push_back(we);
        q_addr.push_back(addr);
        q_be.push_back(be);
        q_wd.push_back(wd);
    endtask

    task automatic clear_logs();
        g_cyc.delete();
        r_cyc.delete();
        r_dat.delete();
    endtask

    // Issues the queued requests back to back with req held high; each one
    // is presented until it is granted.
    task automatic run_reqs(input bit wait_resp);
        int n;
        int guard;
        n = q_we.size();
        clear_logs();
        @(posedge clk); #1;
        for (int k = 0; k < n; k++) begin
            bus.req_i   = 1'b1;
            bus.we_i    = q_we[k];
            bus.addr_i  = q_addr[k];
            bus.be_i    = q_be[k];
            bus.wdata_i = q_wd[k];
            guard = 0;
            do begin
                @(negedge clk); #1;
                guard++;
            end while (g_cyc.size() <= k && guard < 100);
            if (g_cyc.size() <= k) begin
                chk("grant_timeout", g_cyc.size(), k + 1);
                break;
            end
            @(posedge clk); #1;
        end
        bus.req_i   = 1'b0;
        bus.we_i    = 1'b0;
        bus.addr_i  = '0;
        bus.be_i    = '0;
        bus.wdata_i = '0;
        if (wait_resp) begin
            guard = 0;
            while (r_dat.size() < n && guard < 100) begin
                @(negedge clk); #1;
                guard++;
            end
            if (r_dat.size() < n) chk("resp_timeout", r_dat.size(), n);
        end
        q_we.delete();
        q_addr.delete();
        q_be.delete();
        q_wd.delete();
    endtask

    task automatic single(input logic we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wd, output logic [31:0] rd, output int lat);
        add_req(we, addr, be, wd);
        run_reqs(1'b1);
        rd  = (r_dat.size() > 0) ? r_dat[0] : 32'hxxxx_xxxx;
        lat = (r_cyc.size() > 0 && g_cyc.size() > 0) ? (r_cyc[0] - g_cyc[0]) : -1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int          lat;
        int          n;

        bus.req_i   = 1'b0;
        bus.we_i    = 1'b0;
        bus.addr_i  = '0;
        bus.be_i    = '0;
        bus.wdata_i = '0;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rvalid_in_reset", bus.rvalid_o, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rvalid", bus.rvalid_o, 1'b0);
        chk("rst_rdata", bus.rdata_o, 32'h0);
        chk("rst_gnt_idle", bus.gnt_o, 1'b0);

        // T1: write then read, exact latency
        single(1'b1, BASE + 32'h8, 4'hF, 32'hDEAD_BEEF, rd, lat);
        chk("t1_wr_lat", lat, LAT);
        chk("t1_wr_rdata", rd, 32'h0);
        single(1'b0, BASE + 32'h8, 4'h0, 32'h0, rd, lat);
        chk("t1_rd_lat", lat, LAT);
        chk("t1_rd_data", rd, 32'hDEAD_BEEF);

        // T2: byte enables
        single(1'b1, BASE + 32'h10, 4'hF, 32'h1122_3344, rd, lat);
        single(1'b1, BASE + 32'h10, 4'b0101, 32'hAABB_CCDD, rd, lat);
        single(1'b0, BASE + 32'h10, 4'h0, 32'h0, rd, lat);
        chk("t2_be_merge", rd, 32'h11BB_33DD);
        single(1'b0, BASE + 32'h13, 4'h0, 32'h0, rd, lat);
        chk("t2_low_bits_ignored", rd, 32'h11BB_33DD);

        // Preload words used by later tests
        add_req(1'b1, BASE, 4'hF, 32'h0BAD_F00D);
        for (int k = 0; k < 4; k++) add_req(1'b1, BASE + 32'h20 + 32'(4 * k), 4'hF, 32'hA000_0000 + 32'(k));
        add_req(1'b1, BASE + 32'h30, 4'hF, 32'hCAFE_F00D);
        add_req(1'b1, BASE + 32'h3FC, 4'hF, 32'h7777_0001);
        run_reqs(1'b1);

        // T3: four reads with req held; queue of two throttles the grants
        for (int k = 0; k < 4; k++) add_req(1'b0, BASE + 32'h20 + 32'(4 * k), 4'h0, 32'h0);
        run_reqs(1'b1);
        chk("t3_n_resp", r_dat.size(), 4);
        n = (r_dat.size() < 4) ? r_dat.size() : 4;
        if (g_cyc.size() < n) n = g_cyc.size();
        for (int k = 0; k < n; k++) begin
            chk("t3_grant_cycle", g_cyc[k] - g_cyc[0], EXP_G[k]);
            chk("t3_rvalid_cycle", r_cyc[k] - g_cyc[0], EXP_R[k]);
            chk("t3_order_data", r_dat[k], 32'hA000_0000 + 32'(k));
        end
        chk("t3_gnt_while_full", full_gnt, 0);

        // T4: decode boundaries
        single(1'b0, BASE + 32'h400, 4'h0, 32'h0, rd, lat);
        chk("t4_oor_read", rd, 32'hBADC_AB1E);
        single(1'b1, BASE + 32'h400, 4'hF, 32'h1234_5678, rd, lat);
        chk("t4_oor_wr_lat", lat, LAT);
        single(1'b0, BASE + 32'h400, 4'h0, 32'h0, rd, lat);
        chk("t4_oor_read_again", rd, 32'hBADC_AB1E);
        single(1'b0, BASE, 4'h0, 32'h0, rd, lat);
        chk("t4_word0_unchanged", rd, 32'h0BAD_F00D);
        single(1'b0, BASE + 32'h8, 4'h0, 32'h0, rd, lat);
        chk("t4_word2_unchanged", rd, 32'hDEAD_BEEF);
        single(1'b0, BASE + 32'h3FC, 4'h0, 32'h0, rd, lat);
        chk("t4_last_word", rd, 32'h7777_0001);
        single(1'b0, BASE - 32'h4, 4'h0, 32'h0, rd, lat);
        chk("t4_below_base", rd, 32'hBADC_AB1E);

        // T5a: reset lands while a response is on the bus
        add_req(1'b0, BASE + 32'h8, 4'h0, 32'h0);
        run_reqs(1'b0);
        @(posedge clk);
        @(posedge clk); #2;
        chk("t5_pre_rvalid", bus.rvalid_o, 1'b1);
        rst = 1'b1;
        #1;
        chk("t5_rvalid_drop", bus.rvalid_o, 1'b0);
        chk("t5_rdata_drop", bus.rdata_o, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // T5b: reset with two requests outstanding (a write and a read)
        add_req(1'b1, BASE + 32'h34, 4'hF, 32'h5A5A_5A5A);
        add_req(1'b0, BASE + 32'h30, 4'h0, 32'h0);
        run_reqs(1'b0);
        chk("t5_two_granted", g_cyc.size(), 2);
        #1;
        rst = 1'b1;
        #1;
        chk("t5_rvalid_in_reset", bus.rvalid_o, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_logs();
        repeat (10) @(posedge clk);
        #1;
        chk("t5_no_late_rvalid", r_dat.size(), 0);
        single(1'b0, BASE + 32'h34, 4'h0, 32'h0, rd, lat);
        chk("t5_write_kept", rd, 32'h5A5A_5A5A);
        chk("t5_post_reset_lat", lat, LAT);
        single(1'b0, BASE + 32'h30, 4'h0, 32'h0, rd, lat);
        chk("t5_mem_not_reset", rd, 32'hCAFE_F00D);

`ifdef EXT_SLOW_MEM_RAND_LAT_EN
        // T6: random latency stays in range and order is preserved
        for (int k = 0; k < 100; k++) add_req(1'b1, BASE + 32'h100 + 32'(4 * k), 4'hF, 32'h6000_0000 + 32'(k));
        run_reqs(1'b1);
        for (int k = 0; k < 100; k++) add_req(1'b0, BASE + 32'h100 + 32'(4 * k), 4'h0, 32'h0);
        run_reqs(1'b1);
        chk("t6_n_resp", r_dat.size(), 100);
        n = (r_dat.size() < 100) ? r_dat.size() : 100;
        if (g_cyc.size() < n) n = g_cyc.size();
        for (int k = 0; k < n; k++) begin
            lat = r_cyc[k] - g_cyc[k];
            chk("t6_lat_in_range", (lat >= LAT && lat <= LAT + 7), 1'b1);
            chk("t6_order_data", r_dat[k], 32'h6000_0000 + 32'(k));
        end
`endif

        chk("gnt_while_full_total", full_gnt, 0);
        chk("rdata_nonzero_idle", idle_dat, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
